// File: rtl/inst_mem_loader_pkg.sv
// Shared defaults and loader state encoding for the instruction memory
// writer path; also imported by inst_memory.
package inst_mem_loader_pkg;

    localparam int DEF_INSTR_ADDR_WIDTH     = 16;
    localparam int DEF_INSTR_DATA_BIT_WIDTH = 16;
    localparam int DEF_INSTR_MEM_SIZE       = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/inst_mem_loader_if.sv
// Byte stream in and instruction memory write port out, as seen by
// the loader (slave) and by the byte source / memory side (master).
interface inst_mem_loader_if
    import inst_mem_loader_pkg::*;
#(
    parameter int AW = DEF_INSTR_ADDR_WIDTH,
    parameter int DW = DEF_INSTR_DATA_BIT_WIDTH
);

    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_last;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/inst_mem_loader_word_assembler.sv
// Packs bytes MSB-first into one instruction word; flags completion on
// a full word or on the session's last byte (low bytes zero-padded).
module inst_mem_loader_word_assembler
    import inst_mem_loader_pkg::*;
#(
    parameter int DW = DEF_INSTR_DATA_BIT_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          accept,
    input  logic [7:0]    byte_in,
    input  logic          last,
    output logic [DW-1:0] word,
    output logic          word_complete
);

    localparam int BPW = DW / 8;
    localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [IW-1:0] idx_q;
    logic [DW-1:0] asm_q;

    // word includes the byte being accepted this cycle
    always_comb begin
        word = asm_q;
        for (int i = 0; i < BPW; i++) begin
            if (idx_q == IW'(BPW - 1 - i)) begin
                word[8*i +: 8] = byte_in;
            end
        end
    end

    assign word_complete = accept && (last || idx_q == IW'(BPW - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= '0;
            asm_q <= '0;
        end else if (clear || word_complete) begin
            idx_q <= '0;
            asm_q <= '0;
        end else if (accept) begin
            idx_q <= idx_q + IW'(1);
            asm_q <= word;
        end
    end

endmodule

// File: rtl/inst_mem_loader.sv
// Loader FSM: latches the base pointer, bound-checks each completed
// word and issues one registered write per word to instruction memory.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int INSTR_ADDR_WIDTH     = DEF_INSTR_ADDR_WIDTH,
    parameter int INSTR_DATA_BIT_WIDTH = DEF_INSTR_DATA_BIT_WIDTH,
    parameter int INSTR_MEM_SIZE       = DEF_INSTR_MEM_SIZE
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [INSTR_ADDR_WIDTH-1:0] base_addr,
    inst_mem_loader_if.slave            bus,
    output logic                        busy,
    output logic                        done,
    output logic                        exc,
    output logic [INSTR_ADDR_WIDTH:0]   word_count
);

    localparam int AW = INSTR_ADDR_WIDTH;
    localparam int DW = INSTR_DATA_BIT_WIDTH;
    localparam logic [AW:0] MEM_SIZE_W = (AW+1)'(INSTR_MEM_SIZE);

    loader_state_e state_q, state_d;

    logic [AW-1:0] ptr_q;
    logic [AW:0]   wc_q;
    logic          wr_en_q;
    logic [AW-1:0] wr_addr_q;
    logic [DW-1:0] wr_data_q;
    logic          done_q;
    logic          exc_q;

    logic          accept;
    logic          word_complete;
    logic [DW-1:0] word;
    logic          in_bound;
    logic          base_ok;
    logic          load_go;
    logic          bad_go;
    logic          wr_go;
    logic          ovf;

    assign accept   = bus.in_valid && (state_q == ST_LOAD);
    // checked before the increment, so ptr tops out at INSTR_MEM_SIZE
    assign in_bound = {1'b0, ptr_q} < MEM_SIZE_W;
    assign base_ok  = {1'b0, base_addr} < MEM_SIZE_W;

    inst_mem_loader_word_assembler #(
        .DW (DW)
    ) u_asm (
        .clk           (clk),
        .rst           (rst),
        .clear         (load_go),
        .accept        (accept),
        .byte_in       (bus.in_data),
        .last          (bus.in_last),
        .word          (word),
        .word_complete (word_complete)
    );

    always_comb begin
        state_d = state_q;
        load_go = 1'b0;
        bad_go  = 1'b0;
        wr_go   = 1'b0;
        ovf     = 1'b0;
        unique case (state_q)
            ST_LOAD: begin
                if (word_complete) begin
                    if (in_bound) begin
                        wr_go = 1'b1;
                        if (bus.in_last) state_d = ST_DONE;
                    end else begin
                        ovf     = 1'b1;
                        state_d = ST_ERR;
                    end
                end
            end
            default: begin
                if (start) begin
                    if (base_ok) begin
                        load_go = 1'b1;
                        state_d = ST_LOAD;
                    end else begin
                        bad_go  = 1'b1;
                        state_d = ST_ERR;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            wc_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            exc_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_en_q <= wr_go;
            if (load_go) begin
                ptr_q  <= base_addr;
                wc_q   <= '0;
                done_q <= 1'b0;
                exc_q  <= 1'b0;
            end
            if (bad_go) begin
                done_q <= 1'b0;
                exc_q  <= 1'b1;
            end
            if (wr_go) begin
                wr_addr_q <= ptr_q;
                wr_data_q <= word;
                ptr_q     <= ptr_q + AW'(1);
                wc_q      <= wc_q + (AW+1)'(1);
                if (bus.in_last) done_q <= 1'b1;
            end
            if (ovf) exc_q <= 1'b1;
        end
    end

    assign bus.in_ready = (state_q == ST_LOAD);
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign busy         = (state_q == ST_LOAD);
    assign done         = done_q;
    assign exc          = exc_q;
    assign word_count   = wc_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: clean, partial, overflow, bad
// base, stalled stream with stray start, and reset mid-load.
module tb_inst_mem_loader;
    import inst_mem_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic        busy;
    logic        done;
    logic        exc;
    logic [16:0] word_count;

    inst_mem_loader_if bus ();

    inst_mem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .exc        (exc),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic        dn;
        int          cyc;
    } wr_rec_t;

    wr_rec_t wr_q[$];
    int      acc_q[$];
    int      cyc = 0;
    int      vectors = 0;
    int      miscompares = 0;

    always @(posedge clk) cyc++;

    // log writes and byte transfers mid-cycle
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1)
            wr_q.push_back('{bus.wr_addr, bus.wr_data, done, cyc});
        if (bus.in_valid && bus.in_ready === 1'b1)
            acc_q.push_back(cyc);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [15:0] a);
        base_addr = a;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b[8], input int n, input bit lst,
                        input int gap, input int mid_start);
        bit ok;
        for (int k = 0; k < n; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = b[k];
            bus.in_last  = lst && (k == n - 1);
            ok = 1'b0;
            for (int t = 0; t < 20 && !ok; t++) begin
                @(negedge clk);
                ok = (bus.in_ready === 1'b1);
                tick(1);
            end
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL send_timeout byte %0d: in_ready never high", k);
            end
            for (int g = 0; g < gap; g++) begin
                if (k == mid_start && g == 0) begin
                    base_addr = 16'd20;
                    start = 1'b1;
                end
                tick(1);
                start = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        tick(2);
        vectors++;
        if ({bus.in_ready, bus.wr_en, busy, done, exc} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags got %b want 00000",
                     {bus.in_ready, bus.wr_en, busy, done, exc});
        end
        vectors++;
        if (bus.wr_addr !== 16'h0 || bus.wr_data !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_bus got %h/%h want 0000/0000",
                     bus.wr_addr, bus.wr_data);
        end
        vectors++;
        if (word_count !== 17'd0) begin
            miscompares++;
            $display("FAIL reset_wc got %0d want 0", word_count);
        end
        rst = 1'b1;
        tick(1);
        vectors++;
        if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle busy=%b rdy=%b want 0/0", busy, bus.in_ready);
        end
    endtask

    task automatic test_clean(input int gap, input int mid_start, input string nm);
        logic [7:0]  b[8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'h0, 8'h0};
        logic [15:0] ea[3] = '{16'd0, 16'd1, 16'd2};
        logic [15:0] ed[3] = '{16'h1234, 16'h5678, 16'h9ABC};
        logic        edn[3] = '{1'b0, 1'b0, 1'b1};
        int          ci[3] = '{1, 3, 5};
        wr_q.delete();
        acc_q.delete();
        pulse_start(16'd0);
        send(b, 6, 1'b1, gap, mid_start);
        tick(2);
        vectors++;
        if (wr_q.size() != 3 || acc_q.size() != 6) begin
            miscompares++;
            $display("FAIL %s_count writes=%0d bytes=%0d want 3/6",
                     nm, wr_q.size(), acc_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (i < wr_q.size() && ci[i] < acc_q.size()) begin
                vectors++;
                if (wr_q[i].addr !== ea[i] || wr_q[i].data !== ed[i] ||
                    wr_q[i].dn !== edn[i] || wr_q[i].cyc != acc_q[ci[i]] + 1) begin
                    miscompares++;
                    $display("FAIL %s_wr%0d got %h@%0d done=%b cyc=%0d want %h@%0d done=%b cyc=%0d",
                             nm, i, wr_q[i].data, wr_q[i].addr, wr_q[i].dn, wr_q[i].cyc,
                             ed[i], ea[i], edn[i], acc_q[ci[i]] + 1);
                end
            end
        end
        vectors++;
        if (word_count !== 17'd3 || exc !== 1'b0 || done !== 1'b1 ||
            busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_end wc=%0d exc=%b done=%b busy=%b rdy=%b want 3/0/1/0/0",
                     nm, word_count, exc, done, busy, bus.in_ready);
        end
    endtask

    task automatic test_partial();
        logic [7:0] b[8] = '{8'hAA, 8'hBB, 8'hCC, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
        wr_q.delete();
        acc_q.delete();
        pulse_start(16'd10);
        send(b, 3, 1'b1, 0, -1);
        tick(2);
        vectors++;
        if (wr_q.size() != 2) begin
            miscompares++;
            $display("FAIL partial_count got %0d want 2", wr_q.size());
        end else begin
            vectors++;
            if (wr_q[0].addr !== 16'd10 || wr_q[0].data !== 16'hAABB || wr_q[0].dn !== 1'b0) begin
                miscompares++;
                $display("FAIL partial_wr0 got %h@%0d done=%b want aabb@10 done=0",
                         wr_q[0].data, wr_q[0].addr, wr_q[0].dn);
            end
            vectors++;
            if (wr_q[1].addr !== 16'd11 || wr_q[1].data !== 16'hCC00 || wr_q[1].dn !== 1'b1 ||
                wr_q[1].cyc != acc_q[2] + 1) begin
                miscompares++;
                $display("FAIL partial_wr1 got %h@%0d done=%b cyc=%0d want cc00@11 done=1 cyc=%0d",
                         wr_q[1].data, wr_q[1].addr, wr_q[1].dn, wr_q[1].cyc, acc_q[2] + 1);
            end
        end
        vectors++;
        if (done !== 1'b1 || word_count !== 17'd2) begin
            miscompares++;
            $display("FAIL partial_end done=%b wc=%0d want 1/2", done, word_count);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] b[8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0, 8'h0, 8'h0, 8'h0};
        wr_q.delete();
        acc_q.delete();
        pulse_start(16'd63);
        send(b, 4, 1'b1, 0, -1);
        tick(2);
        vectors++;
        if (wr_q.size() != 1 || acc_q.size() != 4) begin
            miscompares++;
            $display("FAIL ovf_count writes=%0d bytes=%0d want 1/4", wr_q.size(), acc_q.size());
        end else begin
            vectors++;
            if (wr_q[0].addr !== 16'd63 || wr_q[0].data !== 16'h0102) begin
                miscompares++;
                $display("FAIL ovf_wr0 got %h@%0d want 0102@63", wr_q[0].data, wr_q[0].addr);
            end
        end
        vectors++;
        if (exc !== 1'b1 || done !== 1'b0 || bus.in_ready !== 1'b0 ||
            busy !== 1'b0 || word_count !== 17'd1) begin
            miscompares++;
            $display("FAIL ovf_end exc=%b done=%b rdy=%b busy=%b wc=%0d want 1/0/0/0/1",
                     exc, done, bus.in_ready, busy, word_count);
        end
    endtask

    task automatic test_bad_base();
        logic [7:0] b[8] = '{8'hDE, 8'hAD, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
        wr_q.delete();
        acc_q.delete();
        pulse_start(16'd64);
        vectors++;
        if (exc !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_base exc=%b done=%b busy=%b rdy=%b want 1/0/0/0",
                     exc, done, busy, bus.in_ready);
        end
        tick(2);
        vectors++;
        if (wr_q.size() != 0) begin
            miscompares++;
            $display("FAIL bad_base_wr got %0d writes want 0", wr_q.size());
        end
        pulse_start(16'd0);
        vectors++;
        if (exc !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL restart exc=%b busy=%b want 0/1", exc, busy);
        end
        send(b, 2, 1'b1, 0, -1);
        tick(2);
        vectors++;
        if (wr_q.size() != 1 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_end writes=%0d done=%b want 1/1", wr_q.size(), done);
        end else begin
            vectors++;
            if (wr_q[0].addr !== 16'd0 || wr_q[0].data !== 16'hDEAD) begin
                miscompares++;
                $display("FAIL restart_wr got %h@%0d want dead@0", wr_q[0].data, wr_q[0].addr);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] b[8] = '{8'h12, 8'h34, 8'h56, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
        wr_q.delete();
        acc_q.delete();
        pulse_start(16'd0);
        send(b, 3, 1'b0, 0, -1);
        #1 rst = 1'b0;
        #1;
        vectors++;
        if ({bus.in_ready, bus.wr_en, busy, done, exc} !== 5'b0 ||
            bus.wr_addr !== 16'h0 || bus.wr_data !== 16'h0 || word_count !== 17'd0) begin
            miscompares++;
            $display("FAIL mid_rst flags=%b addr=%h data=%h wc=%0d want 0",
                     {bus.in_ready, bus.wr_en, busy, done, exc},
                     bus.wr_addr, bus.wr_data, word_count);
        end
        tick(2);
        rst = 1'b1;
        tick(2);
        vectors++;
        if (busy !== 1'b0 || bus.in_ready !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_rst_idle busy=%b rdy=%b done=%b want 0/0/0",
                     busy, bus.in_ready, done);
        end
        vectors++;
        if (wr_q.size() != 1 || wr_q[0].data !== 16'h1234) begin
            miscompares++;
            $display("FAIL mid_rst_wr got %0d writes want 1 (1234 only)", wr_q.size());
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h0;
        bus.in_last  = 1'b0;
        test_reset();
        test_clean(0, -1, "clean");
        test_partial();
        test_overflow();
        test_bad_base();
        test_clean(1, 2, "stall");
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Writer side of the instruction memory: receives a byte stream over a valid/ready handshake and assembles it into instruction words.
- Issues one registered write per word into the instruction memory's write port, starting at a base address latched on start.
- Sits between the boot/debug byte source and the instruction memory.
- Flags an exception on any attempt to write outside memory bounds.

Parameters:
- INSTR_ADDR_WIDTH, 16, width of memory address / write pointer
- INSTR_DATA_BIT_WIDTH, 16, instruction word width; must be a multiple of 8
- INSTR_MEM_SIZE, 64, number of words in instruction memory; valid addresses are 0..INSTR_MEM_SIZE-1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load session (sampled only in IDLE/DONE/ERR)
- base_addr  in  INSTR_ADDR_WIDTH  first word address, latched on start
- in_valid  in  1  byte source has a byte
- in_data  in  8  byte; most significant byte of each word first
- in_last  in  1  qualifies the final byte of the session
- in_ready  out  1  loader accepts a byte; transfer occurs when in_valid & in_ready
- wr_en  out  1  one-cycle write strobe to instruction memory
- wr_addr  out  INSTR_ADDR_WIDTH  write address
- wr_data  out  INSTR_DATA_BIT_WIDTH  write data
- busy  out  1  high in LOAD
- done  out  1  session completed cleanly; held until next start
- exc  out  1  out-of-range write attempted; held until next start
- word_count  out  INSTR_ADDR_WIDTH+1  words written this session

Behaviour:
- BPW = INSTR_DATA_BIT_WIDTH/8 bytes per word.
- Reset (async, rst low): state IDLE. All outputs 0: in_ready, wr_en, wr_addr, wr_data, busy, done, exc, word_count. Byte index, assembly register and pointer cleared. Reset mid-load aborts the session with no further write.
- States: IDLE, LOAD, DONE, ERR.
- IDLE/DONE/ERR + start:
  - base_addr >= INSTR_MEM_SIZE -> ERR, exc=1, done=0.
  - Otherwise -> LOAD: ptr=base_addr, word_count=0, byte index=0, done=0, exc=0.
- start in LOAD: ignored.
- in_ready = 1 exactly when state==LOAD (registered state, no combinational path from in_valid).
- Byte assembly: each accepted byte shifts into the word at position BPW-1-index (MSB first); index increments.
- Word completes when index reaches BPW-1 on an accepted byte, or when in_last is accepted. Missing low bytes are zero-padded.
- On the word-complete cycle:
  - ptr < INSTR_MEM_SIZE: next cycle wr_en=1, wr_addr=ptr, wr_data=word; ptr+1; word_count+1; index=0.
  - ptr >= INSTR_MEM_SIZE: no write; -> ERR, exc=1.
- Write latency: wr_en asserts exactly 1 cycle after acceptance of the completing byte and lasts 1 cycle.
- Gaps in in_valid stall assembly; there is no timeout.
- in_last accepted with a successful write: -> DONE; done=1 in the same cycle wr_en is high.
- ptr never wraps. The bound check precedes the increment, and ptr is at most INSTR_MEM_SIZE before leaving LOAD.
- busy = (state==LOAD). wr_addr/wr_data hold their last values when wr_en=0.

Decomposition:
- Shared package (imported by inst_memory as well):
  - INSTR_ADDR_WIDTH, INSTR_DATA_BIT_WIDTH, INSTR_MEM_SIZE defaults
  - loader state encoding (IDLE=0, LOAD=1, DONE=2, ERR=3)
- One natural sub-module, word_assembler: byte index counter plus shift register, outputs word and word_complete. The FSM, pointer, bound check and write register stay in the top.

Test Plan:
- Clean load:
  - Stimulus: start, base_addr=0; bytes 12 34 56 78 9A BC, in_last on BC, continuous valid.
  - Required: wr_en pulses writing 0x1234@0, 0x5678@1, 0x9ABC@2, each 1 cycle after its 2nd byte; done=1 on the final write cycle; word_count=3; exc=0.
- Partial word:
  - Stimulus: base_addr=10; bytes AA BB CC, in_last on CC.
  - Required: writes 0xAABB@10, then 0xCC00@11; done=1.
- Overflow:
  - Stimulus: base_addr=63; bytes 01 02 03 04, in_last on 04.
  - Required: 0x0102@63 written; completing byte 04 -> no write, exc=1, state ERR, in_ready=0, word_count=1, done=0.
- Bad base / restart:
  - Stimulus: start with base_addr=64.
  - Required: next cycle exc=1, no wr_en. A subsequent start with base_addr=0 clears exc and loads normally.
- Backpressure/stall and ignored start:
  - Stimulus: in_valid toggles every other cycle; start pulsed mid-LOAD.
  - Required: identical write sequence to the clean load, only delayed; the start has no effect.
- Reset mid-load:
  - Stimulus: drop rst after the 3rd byte of the clean-load stream.
  - Required: all outputs 0 immediately (asynchronous), no write of 0x56xx, IDLE after rst rises.
